// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-style floating-point multiplier.
// S1 classifies and unpacks the operands, S2 forms the exponent sum and the
// full significand product, S3 normalises, rounds and packs the result.
// Subnormal operands are treated as zero and tiny results flush to zero.
// Optional macro FPMUL_RNE_EN selects round-to-nearest-even; without it the
// result is truncated toward zero.

module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       num1,
   input  logic [EXP_W+MAN_W:0]       num2,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       product,
   output logic [3:0]                 flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Stage 1 registers
   logic                   s1Valid_q;
   logic                   s1Spec_q;
   logic [W-1:0]           s1SpecRes_q;
   logic [3:0]             s1SpecFlg_q;
   logic                   s1Sign_q;
   logic [EXP_W-1:0]       s1ExpA_q, s1ExpB_q;
   logic [SW-1:0]          s1SigA_q, s1SigB_q;

   // Stage 2 registers
   logic                   s2Valid_q;
   logic                   s2Spec_q;
   logic [W-1:0]           s2SpecRes_q;
   logic [3:0]             s2SpecFlg_q;
   logic                   s2Sign_q;
   logic signed [XW-1:0]   s2Exp_q;
   logic [PW-1:0]          s2Prod_q;

   // Stage 3 (output) registers
   logic                   s3Valid_q;
   logic [W-1:0]           s3Prod_q;
   logic [3:0]             s3Flags_q;

   // Next-state values
   logic                   s1Spec_d;
   logic [W-1:0]           s1SpecRes_d;
   logic [3:0]             s1SpecFlg_d;
   logic signed [XW-1:0]   s2Exp_d;
   logic [PW-1:0]          s2Prod_d;
   logic [W-1:0]           s3Prod_d;
   logic [3:0]             s3Flags_d;

   // Operand fields and classification
   logic                   sA, sB;
   logic [EXP_W-1:0]       eA, eB;
   logic [MAN_W-1:0]       mA, mB;
   logic                   aNan, bNan, aSnan, bSnan, aInf, bInf, aZero, bZero;

   // Normalise / round datapath
   logic                   normHi;
   logic [MAN_W-1:0]       manTrunc;
   logic [SW-1:0]          rest;
   logic                   inexact;
   logic                   roundUp;
   logic [MAN_W:0]         manRounded;
   logic signed [XW-1:0]   expNorm, expRound;

   logic                   advance;

   // The whole pipe moves together; it only freezes when a finished result
   // is waiting for a consumer that is not ready.
   assign advance   = !s3Valid_q || out_ready;
   assign in_ready  = rst || advance;
   assign out_valid = s3Valid_q;
   assign product   = s3Prod_q;
   assign flags     = s3Flags_q;

   assign {sA, eA, mA} = num1;
   assign {sB, eB, mB} = num2;

   assign aNan  = (&eA) && (|mA);
   assign bNan  = (&eB) && (|mB);
   assign aSnan = aNan && !mA[MAN_W-1];
   assign bSnan = bNan && !mB[MAN_W-1];
   assign aInf  = (&eA) && !(|mA);
   assign bInf  = (&eB) && !(|mB);
   assign aZero = !(|eA);
   assign bZero = !(|eB);

   // Resolve NaN / Inf / Zero operands up front so later stages only have to
   // carry the finished special result alongside the normal datapath.
   always_comb begin
      s1Spec_d    = 1'b0;
      s1SpecRes_d = '0;
      s1SpecFlg_d = 4'b0000;
      if (aNan || bNan) begin
         s1Spec_d    = 1'b1;
         s1SpecRes_d = QNAN;
         s1SpecFlg_d = {aSnan || bSnan, 3'b000};
      end else if ((aInf && bZero) || (aZero && bInf)) begin
         s1Spec_d    = 1'b1;
         s1SpecRes_d = QNAN;
         s1SpecFlg_d = 4'b1000;
      end else if (aInf || bInf) begin
         s1Spec_d    = 1'b1;
         s1SpecRes_d = {sA ^ sB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (aZero || bZero) begin
         s1Spec_d    = 1'b1;
         s1SpecRes_d = {sA ^ sB, {(W-1){1'b0}}};
      end
   end

   // Stage 1: capture classification and unpacked fields with hidden bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q   <= 1'b0;
         s1Spec_q    <= 1'b0;
         s1SpecRes_q <= '0;
         s1SpecFlg_q <= 4'b0000;
         s1Sign_q    <= 1'b0;
         s1ExpA_q    <= '0;
         s1ExpB_q    <= '0;
         s1SigA_q    <= '0;
         s1SigB_q    <= '0;
      end else if (advance) begin
         s1Valid_q <= in_valid;
         if (in_valid) begin
            s1Spec_q    <= s1Spec_d;
            s1SpecRes_q <= s1SpecRes_d;
            s1SpecFlg_q <= s1SpecFlg_d;
            s1Sign_q    <= sA ^ sB;
            s1ExpA_q    <= eA;
            s1ExpB_q    <= eB;
            s1SigA_q    <= {1'b1, mA};
            s1SigB_q    <= {1'b1, mB};
         end
      end
   end

   // Biased exponent sum in a signed field wide enough for both overflow
   // and underflow, and the exact double-width significand product.
   assign s2Exp_d  = $signed({2'b00, s1ExpA_q}) + $signed({2'b00, s1ExpB_q}) - BIAS;
   assign s2Prod_d = {{SW{1'b0}}, s1SigA_q} * {{SW{1'b0}}, s1SigB_q};

   // Stage 2: register the exponent sum and full product.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2Valid_q   <= 1'b0;
         s2Spec_q    <= 1'b0;
         s2SpecRes_q <= '0;
         s2SpecFlg_q <= 4'b0000;
         s2Sign_q    <= 1'b0;
         s2Exp_q     <= '0;
         s2Prod_q    <= '0;
      end else if (advance) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            s2Spec_q    <= s1Spec_q;
            s2SpecRes_q <= s1SpecRes_q;
            s2SpecFlg_q <= s1SpecFlg_q;
            s2Sign_q    <= s1Sign_q;
            s2Exp_q     <= s2Exp_d;
            s2Prod_q    <= s2Prod_d;
         end
      end
   end

   // The product of two [1,2) significands lies in [1,4); a set MSB means one
   // extra right shift. The discarded bits are kept MSB-aligned so the top
   // one is always the guard bit.
   always_comb begin
      normHi = s2Prod_q[PW-1];
      if (normHi) begin
         manTrunc = s2Prod_q[PW-2 -: MAN_W];
         rest     = s2Prod_q[MAN_W:0];
      end else begin
         manTrunc = s2Prod_q[PW-3 -: MAN_W];
         rest     = {s2Prod_q[MAN_W-1:0], 1'b0};
      end
   end

   assign inexact = |rest;

`ifdef FPMUL_RNE_EN
   logic guardBit, stickyBit;
   assign guardBit  = rest[SW-1];
   assign stickyBit = |rest[SW-2:0];
   assign roundUp   = guardBit && (stickyBit || manTrunc[0]);
`else
   assign roundUp   = 1'b0;
`endif

   // A carry out of the mantissa leaves the stored field all zero, which is
   // exactly the next power of two once the exponent is bumped.
   assign manRounded = {1'b0, manTrunc} + {{MAN_W{1'b0}}, roundUp};
   assign expNorm    = s2Exp_q + $signed({{(XW-1){1'b0}}, normHi});
   assign expRound   = expNorm + $signed({{(XW-1){1'b0}}, manRounded[MAN_W]});

   // Pack the result, replacing it with Inf on overflow, zero on underflow,
   // or the precomputed special result.
   always_comb begin
      s3Prod_d  = {s2Sign_q, expRound[EXP_W-1:0], manRounded[MAN_W-1:0]};
      s3Flags_d = {3'b000, inexact};
      if (s2Spec_q) begin
         s3Prod_d  = s2SpecRes_q;
         s3Flags_d = s2SpecFlg_q;
      end else if (!expRound[XW-1] && (expRound >= EXP_MAX)) begin
         s3Prod_d  = {s2Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         s3Flags_d = 4'b0101;
      end else if (expRound[XW-1] || (expRound == '0)) begin
         s3Prod_d  = {s2Sign_q, {(W-1){1'b0}}};
         s3Flags_d = 4'b0011;
      end
   end

   // Stage 3: output register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s3Valid_q <= 1'b0;
         s3Prod_q  <= '0;
         s3Flags_q <= 4'b0000;
      end else if (advance) begin
         s3Valid_q <= s2Valid_q;
         if (s2Valid_q) begin
            s3Prod_q  <= s3Prod_d;
            s3Flags_q <= s3Flags_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: randomized self-checking bench for fp_mul_pipe (binary32).
// Honors FPMUL_RNE_EN the same way the design does.

module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] num1, num2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic [3:0]  flags;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0] prod;
      logic [3:0]  flg;
      int          acc;
   } exp_t;

   exp_t expQ[$];
   int   cyc         = 0;
   int   lastStall   = -1;
   bit   prevRst     = 1'b0;
   bit   holdPending = 1'b0;
   bit   randReady   = 1'b0;

   logic [31:0] dirA [10] = '{32'h40400000, 32'h7F800000, 32'hFF800000, 32'h7F000000,
                              32'h00800000, 32'h3FC00001, 32'h7F800001, 32'hFFC00000,
                              32'h80000000, 32'h3F800000};
   logic [31:0] dirB [10] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h7F000000,
                              32'h00800000, 32'h3FC00001, 32'h3F800000, 32'h3F800000,
                              32'h40000000, 32'hBF800000};

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts it and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference multiply from the number-format rules, using exact integer
   // arithmetic on the significands and remainder-vs-half rounding.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
      int     ea  = int'(a[30:23]);
      int     eb  = int'(b[30:23]);
      bit     sgn = a[31] ^ b[31];
      bit     nanA = (ea == 255) && (a[22:0] != 0);
      bit     nanB = (eb == 255) && (b[22:0] != 0);
      bit     infA = (ea == 255) && (a[22:0] == 0);
      bit     infB = (eb == 255) && (b[22:0] == 0);
      bit     zA   = (ea == 0);
      bit     zB   = (eb == 0);
      longint sa, sb, p, keep, rem, half;
      int     e, shift;
      bit     nx;
      f = 4'b0000;
      if (nanA || nanB) begin
         r    = 32'h7FC00000;
         f[3] = (nanA && !a[22]) || (nanB && !b[22]);
         return;
      end
      if ((infA && zB) || (zA && infB)) begin
         r = 32'h7FC00000;
         f = 4'b1000;
         return;
      end
      if (infA || infB) begin
         r = {sgn, 8'hFF, 23'd0};
         return;
      end
      if (zA || zB) begin
         r = {sgn, 31'd0};
         return;
      end
      sa    = {40'd0, 1'b1, a[22:0]};
      sb    = {40'd0, 1'b1, b[22:0]};
      p     = sa * sb;
      e     = ea + eb - 127;
      shift = 23;
      if (p >= (64'sd1 <<< 47)) begin
         shift = 24;
         e++;
      end
      keep = p >>> shift;
      rem  = p - (keep <<< shift);
      half = 64'sd1 <<< (shift - 1);
      nx   = (rem != 0);
`ifdef FPMUL_RNE_EN
      if ((rem > half) || ((rem == half) && keep[0])) keep++;
`else
      if (half < 0) keep++;
`endif
      if (keep >= (64'sd1 <<< 24)) begin
         keep = keep >>> 1;
         e++;
      end
      if (e >= 255) begin
         r = {sgn, 8'hFF, 23'd0};
         f = 4'b0101;
      end else if (e <= 0) begin
         r = {sgn, 31'd0};
         f = 4'b0011;
      end else begin
         r = {sgn, e[7:0], keep[22:0]};
         f = {3'b000, nx};
      end
   endfunction

   // Anchors the reference model to hand-worked results.
   task automatic pinModel(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] wantP, input logic [3:0] wantF);
      logic [31:0] r;
      logic [3:0]  f;
      model(a, b, r, f);
      checkOutput({name, "_prod"}, 64'(r), 64'(wantP));
      checkOutput({name, "_flags"}, 64'(f), 64'(wantF));
   endtask

   // Operands biased toward special values and mid-range exponents.
   function automatic logic [31:0] randOperand();
      logic [7:0]  e;
      logic [22:0] m;
      case ($urandom_range(0, 9))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2, 3:    e = 8'($urandom_range(1, 254));
         default: e = 8'($urandom_range(64, 190));
      endcase
      m = 23'($urandom);
      if ($urandom_range(0, 5) == 0) m = 23'd0;
      return {1'($urandom), e, m};
   endfunction

   // Presents one pair and holds it until accepted, bounded in time.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      int waitCyc = 0;
      num1     = a;
      num2     = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitCyc++;
         if (waitCyc > 200) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: in_ready stayed 0 for %0d cycles, expected 1", waitCyc);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Consumer backpressure: always ready, or pseudo-random stalls.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Mid-cycle scoreboard: records accepted pairs and checks every output.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (prevRst) begin
         checkOutput("validAfterReset", 64'(out_valid), 64'd0);
         checkOutput("productAfterReset", 64'(product), 64'd0);
         checkOutput("flagsAfterReset", 64'(flags), 64'd0);
      end
      if (rst) begin
         checkOutput("readyInReset", 64'(in_ready), 64'd1);
         expQ.delete();
         holdPending = 1'b0;
      end else begin
         if (holdPending) checkOutput("holdValid", 64'(out_valid), 64'd1);
         if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL spurious: product %h emitted, expected no output", product);
            end else begin
               checkOutput("product", 64'(product), 64'(expQ[0].prod));
               checkOutput("flags", 64'(flags), 64'(expQ[0].flg));
               if (out_ready) begin
                  if (lastStall <= expQ[0].acc)
                     checkOutput("latency", 64'(cyc - expQ[0].acc), 64'd3);
                  void'(expQ.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            model(num1, num2, e.prod, e.flg);
            e.acc = cyc;
            expQ.push_back(e);
         end
         holdPending = out_valid && !out_ready;
         if (!out_ready) lastStall = cyc;
      end
      prevRst = rst;
   end

   // Runaway guard.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: still running at %0t, expected completion", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1);
   end

   // Test sequence.
   initial begin
      logic [31:0] rneWant;
      rst       = 1'b1;
      in_valid  = 1'b1;
      num1      = 32'h3F800000;
      num2      = 32'h3F800000;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;

`ifdef FPMUL_RNE_EN
      rneWant = 32'h40100002;
`else
      rneWant = 32'h40100001;
`endif
      pinModel("pin3x2",     32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
      pinModel("pinInfZero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
      pinModel("pinNegInf",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
      pinModel("pinOvf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
      pinModel("pinUnf",     32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
      pinModel("pinRound",   32'h3FC00001, 32'h3FC00001, rneWant,      4'b0001);
      pinModel("pinSnan",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
      pinModel("pinQnan",    32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
      pinModel("pinNegZero", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
      pinModel("pinNegOne",  32'h3F800000, 32'hBF800000, 32'hBF800000, 4'b0000);

      $display("[TB] directed operands, consumer always ready");
      randReady = 1'b0;
      foreach (dirA[i]) applyStimulus(dirA[i], dirB[i]);
      repeat (6) @(posedge clk);
      #1;

      $display("[TB] 8 back-to-back pairs with random backpressure");
      randReady = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(randOperand(), randOperand());

      $display("[TB] reset with two operations in flight");
      randReady = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      applyStimulus(32'h40400000, 32'h40400000);
      applyStimulus(32'h3FC00000, 32'h40000000);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(32'h40400000, 32'h40000000);
      repeat (6) @(posedge clk);
      #1;

      $display("[TB] random traffic with gaps and backpressure");
      randReady = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(randOperand(), randOperand());
      end

      randReady = 1'b0;
      for (int i = 0; (i < 100) && (expQ.size() != 0); i++) @(posedge clk);
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
      end
      repeat (5) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits; legal range 4..11.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width in bits; legal range 3..52.
REQ-003 Local width W = 1+EXP_W+MAN_W, with bias = 2^(EXP_W-1)-1.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair presented.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 num1, num2  input  W each  IEEE-style operands {sign,exp,man}.
REQ-009 out_valid  output  1  product valid.
REQ-010 out_ready  input  1  consumer accepts the product.
REQ-011 product  output  W  result.
REQ-012 flags  output  4  {nv,of,uf,nx}: invalid, overflow, underflow, inexact; aligned with product.

Function
REQ-013 The pipeline SHALL have three register stages: S1 classify/unpack, S2 exponent sum and full (MAN_W+1)x(MAN_W+1) mantissa product, S3 normalise/round/pack.
REQ-014 A global advance = !out_valid | out_ready SHALL gate every stage, and in_ready SHALL equal advance.
REQ-015 A transfer occurs when in_valid&in_ready; its result SHALL appear on out_valid exactly 3 cycles later when out_ready is held high.
REQ-016 Each stage SHALL carry a valid bit; bubbles propagate and no data is lost or duplicated under any out_ready pattern.
REQ-017 While out_valid&!out_ready, product and flags SHALL hold stable.
REQ-018 Classification: NaN = exp all-ones & man!=0; Inf = exp all-ones & man==0; Zero = exp==0, with subnormals flushed to zero and no uf flag.
REQ-019 Result sign SHALL be the XOR of the operand signs, except for NaN results.
REQ-020 Any NaN input, or Inf x Zero, SHALL produce canonical NaN {0, all-ones, 1 followed by zeros}; nv=1 only for Inf x Zero or a NaN whose mantissa MSB is 0.
REQ-021 Inf x finite-nonzero or Inf x Inf SHALL produce signed Inf with all flags 0.
REQ-022 Zero x finite SHALL produce signed zero with all flags 0.
REQ-023 Normal path: sum exponent is biased e1+e2-bias, computed in EXP_W+2 signed bits; the product is normalised by a 1-bit shift when its MSB is set.
REQ-024 If the post-rounding exponent is >= 2^EXP_W-1, the result SHALL be signed Inf with of=1 and nx=1.
REQ-025 If the post-rounding exponent is <= 0, the result SHALL be signed zero with uf=1 and nx=1 (flush-to-zero).
REQ-026 nx SHALL be set when any discarded product bit is 1.
REQ-027 A rounding carry out of the mantissa SHALL increment the exponent and zero the mantissa, then be re-checked against REQ-024.

Reset
REQ-028 When rst is high at a clock edge, all stage valid bits, out_valid, product and flags SHALL be cleared to 0.
REQ-029 During reset cycles in_ready SHALL be 1, and operands presented then SHALL be discarded.
REQ-030 Operations in flight when rst asserts SHALL be dropped and never emitted.

Configuration
REQ-031 Macro FPMUL_RNE_EN: when defined, rounding SHALL be round-to-nearest-even using guard, round and sticky bits.
REQ-032 When FPMUL_RNE_EN is undefined, rounding SHALL be truncation toward zero; nx behaviour is unchanged.

Verification (EXP_W=8, MAN_W=23)
REQ-033 Operands 0x40400000 x 0x40000000 with out_ready=1 -> product 0x40C00000, flags 0000, 3 cycles after acceptance.
REQ-034 Operands 0x7F800000 x 0x00000000 -> product 0x7FC00000, flags 1000; operands 0xFF800000 x 0x40000000 -> product 0xFF800000, flags 0000.
REQ-035 Operands 0x7F000000 x 0x7F000000 -> product 0x7F800000, flags 0101; operands 0x00800000 x 0x00800000 -> product 0x00000000, flags 0011.
REQ-036 Operands 0x3FC00001 squared -> product 0x40100002 with FPMUL_RNE_EN defined, or 0x40100001 without it; flags 0001 in both cases.
REQ-037 Stream 8 back-to-back pairs with out_ready toggling pseudo-randomly -> all 8 products emitted in order with none lost, and product held stable while stalled.
REQ-038 Assert rst with 2 operations in flight -> out_valid=0 on the next cycle, neither result ever emitted, and the next accepted pair returns correctly 3 cycles later.
